dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (MemRead/MemWrite/addr/WriteData/ReadData) among NUM_REQ requesters.
- Requester 0 is the core load/store path; requester 1 is the debug/DMA loader.
- Round-robin arbitration with an optional bounded lock for burst transfers.
- Registers read data and returns it with a one-cycle rvalid pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 32, data width
- ADDR_W, 32, byte address width
- MAX_BURST, 4, max consecutive locked grants to one owner (>=1; 1 disables locking)
- RESET_PRIO, 0, requester index holding highest round-robin priority after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  access request per requester, held until granted
- we  in  NUM_REQ  1 = write, 0 = read
- lock  in  NUM_REQ  request to keep ownership for the next beat
- addr  in  NUM_REQ*ADDR_W  packed byte addresses
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse, cycle after a granted read
- rdata  out  DATA_W  registered read data, valid when any rvalid bit is 1
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_addr  out  ADDR_W  to addr, winner's address passed unchanged
- mem_wdata  out  DATA_W  to WriteData
- mem_rdata  in  DATA_W  from ReadData (combinational memory read)

Behaviour:
- Clock is clk; reset rst_n is asynchronous, active-low. On reset: state=ARB, rr_ptr=RESET_PRIO, burst_cnt=0, rvalid=0, rdata=0. gnt, mem_read and mem_write are 0 while rst_n=0.
- One access per cycle. The winner sees gnt=1 in the same cycle and drives mem_* that cycle. A write commits at the next posedge. A read captures mem_rdata into rdata at the posedge; rvalid[winner]=1 for exactly one cycle after.
- mem_read = gnt & !we; mem_write = gnt & we. Both are 0 with no grant, and mem_addr/mem_wdata are then 0.
- FSM state ARB:
  - Winner is the first requesting index starting at rr_ptr, wrapping modulo NUM_REQ.
  - After a grant, rr_ptr = winner+1 (mod NUM_REQ).
  - If the winner has lock=1 and MAX_BURST>1: go to LOCKED, owner=winner, burst_cnt=1.
- FSM state LOCKED(owner):
  - Only the owner can be granted; other requesters see gnt=0 even if owner req=0.
  - If the owner has req=1 and lock=1, it is granted and burst_cnt increments.
  - Return to ARB when any of these holds: owner req=0; owner lock=0, where that final beat is still granted if req=1; or burst_cnt reaches MAX_BURST after the current grant.
  - On exit, rr_ptr = owner+1 and burst_cnt=0.
- Simultaneous requests: rotation guarantees each requester a grant within NUM_REQ*MAX_BURST cycles.
- A new grant on a cycle where rvalid is high is legal: back-to-back reads give rvalid on consecutive cycles.
- Read and write to the same address in consecutive cycles: the read observes the written value (write commits before the read's combinational access).
- Reset mid-burst drops to ARB. A pending rvalid is cancelled, and a write in flight at reset assertion is not guaranteed.
- X on inputs with req=0 must not propagate to mem_* outputs.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grants (NUM_REQ*32) and stat_stalls (NUM_REQ*32), plus input stat_clr (1).
  - Per requester: grants counts granted cycles; stalls counts cycles with req=1 & gnt=0.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and clear synchronously when stat_clr=1 (clear wins over increment).
- Undefined: ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds: arb_state_e {ARB, LOCKED}, DMEM_DATA_W=32, DMEM_ADDR_W=32, and function rr_pick(req, ptr) returning a one-hot winner.
- One sub-module: dmem_arb_rr_pick (combinational rotate-priority encoder).
- FSM, counters and read-return register stay in dmem_arbiter.

Test Plan:
- Reset then req0 write addr 0x10 data 0xDEADBEEF, then req0 read 0x10 -> gnt0 each cycle; rdata=0xDEADBEEF with rvalid=2'b01 the cycle after the read grant.
- req0 and req1 reads held 6 cycles, lock=0 -> grants alternate 01,10,01,10,... starting with RESET_PRIO=0.
- req1 locked burst of 6 reads with MAX_BURST=4 while req0 held -> gnt1 for 4 cycles, then gnt0 one cycle, then gnt1 resumes.
- req0 lock=1 for 2 beats then lock=0, req1 waiting -> gnt0 x3 (the lock=0 beat still granted), then gnt1.
- rst_n low mid-burst after a read grant -> rvalid stays 0, gnt=0, mem_read=0 during reset; first grant after release goes to RESET_PRIO.
- With DMEM_ARB_STATS_EN: req1 stalled 3 cycles then granted 2 -> stat_stalls[1]=3, stat_grants[1]=2; stat_clr -> both 0 next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The rotate-priority pick works on a fixed 4-bit vector. This is the largest
// supported requester count, and narrower users zero-extend their inputs.
package dmem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 32;
   localparam int RR_MAX      = 4;

   // Returns a one-hot vector selecting the first set bit of req.
   // The search starts at ptr and wraps modulo n.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input logic [1:0]        ptr,
                                                 input int                n);
      logic [RR_MAX-1:0] win;
      logic              found;
      logic [1:0]        idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         idx = 2'((int'(ptr) + k) % n);
         if (k < n && !found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational rotate-priority encoder: one-hot winner among req, searching
// upward from ptr with wrap-around.
module dmem_arb_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [RR_MAX-1:0] req_ext;
   logic [RR_MAX-1:0] win;
   logic              win_unused;

   // Widen the request vector to the helper's size and narrow the result back.
   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
      win                  = rr_pick(req_ext, ptr, NUM_REQ);
      gnt                  = win[NUM_REQ-1:0];
   end

   // The upper bits are always zero when NUM_REQ < RR_MAX.
   assign win_unused = ^win;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// It supports bounded locked bursts and registers the read data it returns.
// Optional macro DMEM_ARB_STATS_EN adds per-requester grant/stall counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int ADDR_W     = DMEM_ADDR_W,
   parameter int MAX_BURST  = 4,
   parameter int RESET_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    we,
   input  logic [NUM_REQ-1:0]    lock,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [NUM_REQ*32-1:0] stat_grants,
   output logic [NUM_REQ*32-1:0] stat_stalls
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e         state, state_nxt;
   logic [1:0]         rr_ptr, rr_ptr_nxt;
   logic [1:0]         owner, owner_nxt;
   logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt, burst_cnt_inc;
   logic [NUM_REQ-1:0] pick;
   logic [NUM_REQ-1:0] owner_oh;
   logic [1:0]         win_idx;
   logic               win_lock, owner_req, owner_lock;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
   endfunction

   dmem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req (req),
      .ptr (rr_ptr),
      .gnt (pick)
   );

   assign burst_cnt_inc = burst_cnt + CNT_W'(1);

   // Decode the free-arbitration winner and the locked owner's request/lock bits.
   always_comb begin
      win_idx    = 2'd0;
      win_lock   = 1'b0;
      owner_oh   = '0;
      owner_req  = 1'b0;
      owner_lock = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            win_idx  = 2'(i);
            win_lock = lock[i];
         end
         if (owner == 2'(i)) begin
            owner_oh[i] = 1'b1;
            owner_req   = req[i];
            owner_lock  = lock[i];
         end
      end
   end

   // Grant and next-state logic. All grants are held off while reset is asserted.
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      owner_nxt     = owner;
      burst_cnt_nxt = burst_cnt;
      gnt           = '0;
      if (rst_n) begin
         case (state)
            ARB: begin
               gnt = pick;
               if (|pick) begin
                  rr_ptr_nxt = next_idx(win_idx);
                  if (win_lock && MAX_BURST > 1) begin
                     state_nxt     = LOCKED;
                     owner_nxt     = win_idx;
                     burst_cnt_nxt = CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (owner_req) gnt = owner_oh;
               if (owner_req && owner_lock && burst_cnt_inc != CNT_W'(MAX_BURST)) begin
                  burst_cnt_nxt = burst_cnt_inc;
               end else begin
                  state_nxt     = ARB;
                  rr_ptr_nxt    = next_idx(owner);
                  burst_cnt_nxt = '0;
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   // Steer the winner onto the memory port. Ungranted requesters contribute
   // nothing, so undriven or X inputs on idle requesters never reach mem_*.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            mem_read  = !we[i];
            mem_write = we[i];
            mem_addr  = addr[i*ADDR_W +: ADDR_W];
            mem_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Arbitration state register.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB;
         rr_ptr    <= 2'(RESET_PRIO);
         owner     <= 2'd0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         owner     <= owner_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Read return: capture memory data on a granted read and pulse rvalid one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= mem_read ? gnt : '0;
         if (mem_read) rdata <= mem_rdata;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] grant_cnt [NUM_REQ];
   logic [31:0] stall_cnt [NUM_REQ];

   // Per-requester saturating grant/stall counters. A clear beats an increment.
   // NOTE: these few counter words need a defined start value, so they are reset like any other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] <= '0;
            stall_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_clr) begin
               grant_cnt[i] <= '0;
               stall_cnt[i] <= '0;
            end else begin
               if (gnt[i] && grant_cnt[i] != 32'hFFFF_FFFF)
                  grant_cnt[i] <= grant_cnt[i] + 32'd1;
               if (req[i] && !gnt[i] && stall_cnt[i] != 32'hFFFF_FFFF)
                  stall_cnt[i] <= stall_cnt[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_grants[g*32 +: 32] = grant_cnt[g];
      assign stat_stalls[g*32 +: 32] = stall_cnt[g];
   end
`else
   // Statistics disabled: no counters, arbitration unchanged.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (NUM_REQ=2, MAX_BURST=4, RESET_PRIO=0).
// A queue-free reference model tracks the rotation pointer and the remaining
// lock budget, and predicts every output on each falling edge.
// Directed sequences add hand-computed grant and read-return expectations.
// Counter checks run when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MB = 4;
   localparam int RP = 0;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, we, lock;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
   logic            mem_read, mem_write;
   logic [AW-1:0]   mem_addr;
`ifdef DMEM_ARB_STATS_EN
   logic            stat_clr;
   logic [N*32-1:0] stat_grants, stat_stalls;
`endif

   logic [31:0] mem [0:63];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .RESET_PRIO(RP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .lock      (lock),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_grants (stat_grants),
      .stat_stalls (stat_stalls)
`endif
   );

   // Word-addressed memory: combinational read, write at the clock edge.
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model state.
   bit           m_locked;
   int           m_ptr, m_owner, m_left;
   logic [N-1:0] m_rv;
   logic [DW-1:0] m_rd;

   always @(negedge clk) begin : model
      logic [N-1:0]  eg;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      int            w;
      if (!rst_n) begin
         m_locked = 0;
         m_ptr    = RP;
         m_rv     = '0;
         m_rd     = '0;
         check("m_rst_gnt", 32'(gnt), 32'd0);
         check("m_rst_rvalid", 32'(rvalid), 32'd0);
         check("m_rst_rdata", rdata, 32'd0);
         check("m_rst_mem_read", 32'(mem_read), 32'd0);
         check("m_rst_mem_write", 32'(mem_write), 32'd0);
      end else begin
         w = -1;
         if (m_locked) begin
            if (req[m_owner]) w = m_owner;
         end else begin
            for (int k = 0; k < N; k++)
               if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
         eg = '0; ea = '0; ed = '0;
         if (w >= 0) begin
            eg[w] = 1'b1;
            ea    = addr[w*AW +: AW];
            ed    = wdata[w*DW +: DW];
         end
         check("m_gnt", 32'(gnt), 32'(eg));
         check("m_rvalid", 32'(rvalid), 32'(m_rv));
         check("m_rdata", rdata, m_rd);
         check("m_mem_read", 32'(mem_read), 32'(w >= 0 && !we[w]));
         check("m_mem_write", 32'(mem_write), 32'(w >= 0 && we[w]));
         check("m_mem_addr", mem_addr, ea);
         check("m_mem_wdata", mem_wdata, ed);
         // Advance the model to the next cycle.
         m_rv = '0;
         if (w >= 0 && !we[w]) begin
            m_rv = eg;
            m_rd = mem[ea[7:2]];
         end
         if (m_locked) begin
            if (!req[m_owner] || !lock[m_owner]) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_locked = 0;
                  m_ptr    = (m_owner + 1) % N;
               end
            end
         end else if (w >= 0) begin
            m_ptr = (w + 1) % N;
            if (lock[w] && MB > 1) begin
               m_locked = 1;
               m_owner  = w;
               m_left   = MB - 1;
            end
         end
      end
   end

   // One cycle of stimulus with a literal grant expectation.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] w_e, input logic [N-1:0] lk,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [N-1:0] exp_g, input string nm);
      req = r; we = w_e; lock = lk;
      addr  = {a1, a0};
      wdata = {d1, d0};
      @(negedge clk);
      check(nm, 32'(gnt), 32'(exp_g));
      @(posedge clk); #1;
   endtask

   // Idle cycle that checks a literal read return.
   task automatic expect_ret(input logic [N-1:0] exp_rv, input logic [DW-1:0] exp_rd, input string nm);
      req = '0; we = '0; lock = '0;
      @(negedge clk);
      check({nm, "_rvalid"}, 32'(rvalid), 32'(exp_rv));
      check({nm, "_rdata"}, rdata, exp_rd);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; we = '0; lock = '0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      rst_n = 1'b1;
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
`ifdef DMEM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      #2 rst_n = 1'b0;
      req = 2'b11;
      @(negedge clk);
      check("rst_gnt_gated", 32'(gnt), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Write then read back through requester 0.
      step(2'b01, 2'b01, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 2'b01, "t1_write");
      step(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, "t1_read");
      expect_ret(2'b01, 32'hDEADBEEF, "t1_ret");

      // Plain round-robin from reset priority, back-to-back reads.
      do_reset();
      for (int i = 0; i < 6; i++)
         step(2'b11, 2'b00, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0,
              (i % 2 == 0) ? 2'b01 : 2'b10, "t2_alt");

      // Requester 1 locked burst capped at MAX_BURST, then rotation, then resume.
      step(2'b10, 2'b00, 2'b10, 32'h0, 32'h40, 32'h0, 32'h0, 2'b10, "t3_beat1");
      for (int i = 1; i < 4; i++)
         step(2'b11, 2'b00, 2'b10, 32'h80, 32'h40 + 32'(4*i), 32'h0, 32'h0, 2'b10, "t3_locked");
      step(2'b11, 2'b00, 2'b10, 32'h80, 32'h50, 32'h0, 32'h0, 2'b01, "t3_rotate");
      step(2'b11, 2'b00, 2'b10, 32'h80, 32'h54, 32'h0, 32'h0, 2'b10, "t3_resume");
      step(2'b11, 2'b00, 2'b10, 32'h80, 32'h58, 32'h0, 32'h0, 2'b10, "t3_resume2");
      step(2'b01, 2'b00, 2'b10, 32'h84, 32'h58, 32'h0, 32'h0, 2'b00, "t3_owner_drop");
      step(2'b01, 2'b00, 2'b00, 32'h84, 32'h0, 32'h0, 32'h0, 2'b01, "t3_after");

      // Requester 0 locks two beats, third beat unlocked but granted; then req1 reads it.
      step(2'b01, 2'b01, 2'b01, 32'h30, 32'h30, 32'h11111111, 32'h0, 2'b01, "t4_b1");
      step(2'b11, 2'b01, 2'b01, 32'h30, 32'h30, 32'h22222222, 32'h0, 2'b01, "t4_b2");
      step(2'b11, 2'b01, 2'b00, 32'h30, 32'h30, 32'h33333333, 32'h0, 2'b01, "t4_b3");
      step(2'b11, 2'b00, 2'b00, 32'h30, 32'h30, 32'h0, 32'h0, 2'b10, "t4_req1");
      expect_ret(2'b10, 32'h33333333, "t4_ret");

      // Reset mid-burst right after a read grant.
      step(2'b10, 2'b00, 2'b10, 32'h0, 32'h44, 32'h0, 32'h0, 2'b10, "t5_grant");
      rst_n = 1'b0;
      req = 2'b11; lock = 2'b11;
      @(negedge clk);
      check("t5_rvalid_cancel", 32'(rvalid), 32'd0);
      check("t5_gnt_in_reset", 32'(gnt), 32'd0);
      check("t5_mem_read_in_reset", 32'(mem_read), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(2'b11, 2'b00, 2'b00, 32'h8, 32'hC, 32'h0, 32'h0, 2'b01, "t5_first");

      // X on an idle requester must not leak onto the memory port.
      step(2'b01, 2'bx0, 2'bx0, 32'h50, 'x, 32'h0, 'x, 2'b01, "x_isolate");
      step(2'b00, 2'bxx, 2'bxx, 'x, 'x, 'x, 'x, 2'b00, "x_idle");

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      stat_clr = 1'b1;
      step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, "s_clr");
      stat_clr = 1'b0;
      step(2'b11, 2'b00, 2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 2'b01, "s_b1");
      step(2'b11, 2'b00, 2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 2'b01, "s_b2");
      step(2'b11, 2'b00, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 2'b01, "s_b3");
      step(2'b10, 2'b00, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 2'b10, "s_g1");
      step(2'b10, 2'b00, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 2'b10, "s_g2");
      req = '0; lock = '0;
      @(negedge clk);
      check("s_stalls1", stat_stalls[63:32], 32'd3);
      check("s_grants1", stat_grants[63:32], 32'd2);
      check("s_grants0", stat_grants[31:0], 32'd3);
      check("s_stalls0", stat_stalls[31:0], 32'd0);
      @(posedge clk); #1;
      stat_clr = 1'b1;
      req = 2'b11;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      req = '0;
      @(negedge clk);
      check("s_clr_grants", stat_grants[31:0] | stat_grants[63:32], 32'd0);
      check("s_clr_stalls", stat_stalls[31:0] | stat_stalls[63:32], 32'd0);
      @(posedge clk); #1;
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
